// File: rtl/daq_fifo_reader.sv
// -----------------------------------------------------------------------------
// daq_fifo_reader
//   Read-side consumer of the DAQ sample FIFO. Pops payload bytes one at a
//   time, frames them as {HDR_BYTE, sequence, payload[PAYLOAD]} and streams
//   the frame to the host link over a valid/ready byte interface.
//
//   Optional feature macro: DAQ_FIFO_CSUM_EN
//     defined   -> a trailing checksum byte (seq + sum of payload, mod 256)
//                  carries tx_eof_o; frame is PAYLOAD+3 bytes.
//     undefined -> tx_eof_o marks the last payload byte; frame is PAYLOAD+2.
//
// Ports
//   clk_i       in   1   single clock (FIFO read clock domain)
//   reset_i     in   1   asynchronous, active-high reset
//   en_i        in   1   allow new frames to start (sampled only in IDLE)
//   rdempty_i   in   1   FIFO read-side empty
//   fifo_q_i    in   8   FIFO read data, valid the cycle after rdreq_o
//   rdreq_o     out  1   FIFO pop strobe, one-cycle pulse
//   tx_data_o   out  8   link byte
//   tx_valid_o  out  1   tx_data_o valid
//   tx_ready_i  in   1   link accepts byte when tx_valid_o & tx_ready_i
//   tx_sof_o    out  1   marks header byte
//   tx_eof_o    out  1   marks last byte of frame
//   seq_o       out  8   sequence number of current/next frame
//   busy_o      out  1   high in any state other than IDLE
// -----------------------------------------------------------------------------
module daq_fifo_reader #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    NUM_CH       = 8,
  parameter int                    BYTES_PER_CH = 2,
  parameter logic [DATA_WIDTH-1:0] HDR_BYTE     = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  rdempty_i,
  input  logic [DATA_WIDTH-1:0] fifo_q_i,
  output logic                  rdreq_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  tx_sof_o,
  output logic                  tx_eof_o,
  output logic [DATA_WIDTH-1:0] seq_o,
  output logic                  busy_o
);

  localparam int PAYLOAD = NUM_CH * BYTES_PER_CH;
  localparam int CNT_W   = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    SEQ    = 3'd2,
    FETCH  = 3'd3,
    WAIT_Q = 3'd4,
    SEND   = 3'd5,
    CSUM   = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_seq;
`ifdef DAQ_FIFO_CSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
`endif

  logic                  w_rdreq;
  logic                  w_tx_valid;
  logic                  w_sof;
  logic                  w_eof;
  logic [DATA_WIDTH-1:0] w_tx_data;
  logic                  w_last;
  logic                  w_accept;

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = w_tx_valid & tx_ready_i;

  // Next-state and outputs. Outputs depend only on the state and registered
  // data, so they stay stable for as long as the link stalls a byte.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next     = r_state;
    w_rdreq    = 1'b0;
    w_tx_valid = 1'b0;
    w_sof      = 1'b0;
    w_eof      = 1'b0;
    w_tx_data  = '0;
    case (r_state)
      IDLE: begin
        if (en_i && !rdempty_i) w_next = HDR;
      end
      HDR: begin
        w_tx_data  = HDR_BYTE;
        w_tx_valid = 1'b1;
        w_sof      = 1'b1;
        if (tx_ready_i) w_next = SEQ;
      end
      SEQ: begin
        w_tx_data  = r_seq;
        w_tx_valid = 1'b1;
        if (tx_ready_i) w_next = FETCH;
      end
      FETCH: begin
        // Underrun simply waits here; the pop is gated by rdempty_i directly.
        if (!rdempty_i) begin
          w_rdreq = 1'b1;
          w_next  = WAIT_Q;
        end
      end
      WAIT_Q: begin
        w_next = SEND;
      end
      SEND: begin
        w_tx_data  = r_hold;
        w_tx_valid = 1'b1;
`ifdef DAQ_FIFO_CSUM_EN
        if (tx_ready_i) w_next = w_last ? CSUM : FETCH;
`else
        w_eof = w_last;
        if (tx_ready_i) w_next = w_last ? IDLE : FETCH;
`endif
      end
`ifdef DAQ_FIFO_CSUM_EN
      CSUM: begin
        w_tx_data  = r_csum;
        w_tx_valid = 1'b1;
        w_eof      = 1'b1;
        if (tx_ready_i) w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      // NOTE: the hold byte is a single register, not a memory array, so it
      // is cheap to reset and keeps tx_data_o deterministic after reset.
      r_hold  <= '0;
      r_seq   <= '0;
`ifdef DAQ_FIFO_CSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_next;

      // fifo_q_i is valid the cycle after the pop, i.e. while in WAIT_Q.
      if (r_state == WAIT_Q) r_hold <= fifo_q_i;

      if (r_state == SEND && w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end

`ifdef DAQ_FIFO_CSUM_EN
      if (r_state == SEQ && w_accept)  r_csum <= r_seq;
      if (r_state == SEND && w_accept) r_csum <= r_csum + r_hold;
`endif

      // Sequence advances when the frame's final byte is taken by the link.
      if (w_accept && w_eof) r_seq <= r_seq + DATA_WIDTH'(1);
    end
  end

  assign rdreq_o    = w_rdreq;
  assign tx_data_o  = w_tx_data;
  assign tx_valid_o = w_tx_valid;
  assign tx_sof_o   = w_sof;
  assign tx_eof_o   = w_eof;
  assign seq_o      = r_seq;
  assign busy_o     = (r_state != IDLE);

endmodule
